// File: rtl/pmmu_hs_if.sv
`default_nettype none
// ============================================================================
// Module  : pmmu_hs_if
// Brief   : Request/busy/ready memory handshake bundle between core and PMMU.
// Revision: 1.0
// ============================================================================
interface pmmu_hs_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] byte_addr_i;
  logic [DATA_WIDTH-1:0] wd_i;
  logic [DATA_WIDTH-1:0] rd_o;
  logic                  busy_o;
  logic                  rdy_o;
  logic                  misalign_o;
  logic                  fault_o;

  modport master (
    output req_i, we_i, funct3_i, byte_addr_i, wd_i,
    input  rd_o, busy_o, rdy_o, misalign_o, fault_o
  );

  modport slave (
    input  req_i, we_i, funct3_i, byte_addr_i, wd_i,
    output rd_o, busy_o, rdy_o, misalign_o, fault_o
  );
endinterface
`default_nettype wire

// File: rtl/pmmu_hs.sv
`default_nettype none
// ============================================================================
// Module  : pmmu_hs
// Brief   : RV32I data memory with request/busy/ready handshake, wait states,
//           sub-word access and error flags. Store protection of the low
//           PROTECT_WORDS words is enabled by defining PMMU_WRITE_PROTECT_EN.
// Revision: 1.0
// ============================================================================
module pmmu_hs #(
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS         = 1024,
  parameter int WAIT_STATES   = 1,
  parameter int PROTECT_WORDS = 16
) (
  input  wire logic clk_i,
  input  wire logic reset_i,
  pmmu_hs_if.slave  bus
);
  localparam int         c_IDX_W = $clog2(WORDS);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);
`ifdef PMMU_WRITE_PROTECT_EN
  localparam logic       c_WP_EN = 1'b1;
`else
  localparam logic       c_WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [2:0]            r_f3;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wd;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_misalign;
  logic                  r_fault;
  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic                  w_we;
  logic [2:0]            w_f3;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_word;
  logic [c_IDX_W-1:0]    w_idx;
  logic                  w_misalign;
  logic                  w_bad_f3;
  logic                  w_range;
  logic                  w_prot;
  logic                  w_fault;
  logic                  w_ok;
  logic                  w_enter_done;
  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_load;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;

  // With zero wait states DONE is entered on the accepting edge, so the
  // access is evaluated from the live inputs while idle.
  always_comb begin
    w_we   = r_we;
    w_f3   = r_f3;
    w_addr = r_addr;
    w_wd   = r_wd;
    if (r_state == S_IDLE) begin
      w_we   = bus.we_i;
      w_f3   = bus.funct3_i;
      w_addr = bus.byte_addr_i;
      w_wd   = bus.wd_i;
    end
  end

  assign w_word     = {2'b00, w_addr[DATA_WIDTH-1:2]};
  assign w_idx      = w_addr[c_IDX_W+1:2];
  assign w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_bad_f3   = w_we ? (w_f3[2] || (w_f3[1:0] == 2'b11))
                           : ((w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111));
  assign w_range    = (w_word >= DATA_WIDTH'(WORDS));
  assign w_prot     = c_WP_EN && w_we && (w_word < DATA_WIDTH'(PROTECT_WORDS));
  assign w_fault    = w_bad_f3 || w_range || w_prot;
  assign w_ok       = !w_misalign && !w_fault;

  assign w_rword = mem[w_idx];
  assign w_byte  = w_rword[{w_addr[1:0], 3'b000} +: 8];
  assign w_half  = w_rword[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (w_f3)
      3'b000:  w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      3'b100:  w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      3'b001:  w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      3'b101:  w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
      default: w_load = w_rword;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = w_wd;
    case (w_f3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {(DATA_WIDTH/8){w_wd[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(DATA_WIDTH/16){w_wd[15:0]}};
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    w_next     = r_state;
    bus.busy_o = 1'b0;
    bus.rdy_o  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_i) w_next = (c_WAIT == 4'd0) ? S_DONE : S_WAIT;
      S_WAIT: begin
        bus.busy_o = 1'b1;
        if (r_cnt <= 4'd1) w_next = S_DONE;
      end
      S_DONE: begin
        bus.rdy_o = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == S_DONE) && (r_state != S_DONE);
  // Gated by reset so an access presented during reset can never commit.
  assign w_commit     = reset_i && w_enter_done && w_ok && w_we;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_f3       <= 3'd0;
      r_addr     <= '0;
      r_wd       <= '0;
      r_rd       <= '0;
      r_misalign <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && bus.req_i) begin
        r_we   <= bus.we_i;
        r_f3   <= bus.funct3_i;
        r_addr <= bus.byte_addr_i;
        r_wd   <= bus.wd_i;
        r_cnt  <= c_WAIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      r_misalign <= w_enter_done && w_misalign;
      r_fault    <= w_enter_done && w_fault;
      if (w_enter_done && w_ok && !w_we) r_rd <= w_load;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  assign bus.rd_o       = r_rd;
  assign bus.misalign_o = r_misalign;
  assign bus.fault_o    = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_pmmu_hs.sv
`default_nettype none
// ============================================================================
// Module  : tb_pmmu_hs
// Brief   : Self-checking bench: three pmmu_hs instances (1, 3, 0 wait states)
//           against a byte-addressed reference model. Honours PMMU_WRITE_PROTECT_EN.
// Revision: 1.0
// ============================================================================
module tb_pmmu_hs;
  localparam int NI = 3;
`ifdef PMMU_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam bit [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn [NI];
  logic        req  [NI];
  logic        we   [NI];
  logic [2:0]  f3   [NI];
  logic [31:0] addr [NI];
  logic [31:0] wd   [NI];
  logic [31:0] rd   [NI];
  logic        busy [NI];
  logic        rdy  [NI];
  logic        mis  [NI];
  logic        flt  [NI];

  int vectors     = 0;
  int miscompares = 0;

  bit   [7:0]  mb  [NI][4096];
  logic [31:0] mrd [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pmmu_hs_if #(.DATA_WIDTH(32)) u_bus ();
    assign u_bus.req_i       = req[g];
    assign u_bus.we_i        = we[g];
    assign u_bus.funct3_i    = f3[g];
    assign u_bus.byte_addr_i = addr[g];
    assign u_bus.wd_i        = wd[g];
    assign rd[g]             = u_bus.rd_o;
    assign busy[g]           = u_bus.busy_o;
    assign rdy[g]            = u_bus.rdy_o;
    assign mis[g]            = u_bus.misalign_o;
    assign flt[g]            = u_bus.fault_o;

    pmmu_hs #(
      .DATA_WIDTH   (32),
      .WORDS        (1024),
      .WAIT_STATES  ((g == 0) ? 1 : (g == 1) ? 3 : 0),
      .PROTECT_WORDS(16)
    ) u_dut (
      .clk_i  (clk),
      .reset_i(rstn[g]),
      .bus    (u_bus.slave)
    );
  end

  function automatic int ws_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory seen as little-endian bytes; accesses are n = 2**funct3[1:0] bytes.
  task automatic model(input int k, input bit w, input bit [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d, output bit emis, output bit eflt);
    int          n;
    bit          legal;
    logic [31:0] v;
    n     = 1 << fn[1:0];
    emis  = (n == 2 || n == 4) && (a % n != 0);
    legal = w ? (fn <= 3'd2) : (fn inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    eflt  = !legal || (a / 4 >= 1024) || (WP && w && (a / 4 < 16));
    if (!emis && !eflt) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[k][a + i] = d[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[k][a + i]) << (8 * i));
        if (!fn[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        mrd[k] = v;
      end
    end
  endtask

  task automatic access(input int k, input bit w, input bit [2:0] fn, input logic [31:0] a,
                        input logic [31:0] d, input bit hold, input string tag);
    bit emis, eflt;
    int edges, busyc;
    model(k, w, fn, a, d, emis, eflt);
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; f3[k] = fn; addr[k] = a; wd[k] = d;
    @(posedge clk); #1;
    if (!hold) req[k] = 1'b0;
    edges = 1;
    busyc = 0;
    while (rdy[k] !== 1'b1 && edges < 40) begin
      if (busy[k] === 1'b1) busyc++;
      @(posedge clk); #1;
      edges++;
    end
    chk({tag, " rdy"},      32'(rdy[k]),  32'd1);
    chk({tag, " latency"},  edges,        ws_of(k) + 1);
    chk({tag, " busy_cyc"}, busyc,        ws_of(k));
    chk({tag, " busy@rdy"}, 32'(busy[k]), 32'd0);
    chk({tag, " misalign"}, 32'(mis[k]),  32'(emis));
    chk({tag, " fault"},    32'(flt[k]),  32'(eflt));
    chk({tag, " rd"},       rd[k],        mrd[k]);
    if (hold) begin
      @(negedge clk);
      req[k] = 1'b0;
    end
    @(posedge clk); #1;
    chk({tag, " rdy_pulse"}, 32'(rdy[k]), 32'd0);
    if (hold) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        chk({tag, " no_reaccept"}, 32'({busy[k], rdy[k]}), 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] ra, rdv;
    bit          rw;
    bit [2:0]    rf;
    for (int k = 0; k < NI; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; f3[k] = 3'd0;
      addr[k] = 32'd0; wd[k] = 32'd0; mrd[k] = 32'd0;
    end
    #12;
    for (int k = 0; k < NI; k++) begin
      chk("reset rdy",      32'(rdy[k]),  32'd0);
      chk("reset busy",     32'(busy[k]), 32'd0);
      chk("reset misalign", 32'(mis[k]),  32'd0);
      chk("reset fault",    32'(flt[k]),  32'd0);
      chk("reset rd",       rd[k],        32'd0);
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) rstn[k] = 1'b1;

    // Word and sub-word traffic, one wait state
    access(0, 1'b1, LW, 32'h100, 32'hDEAD_BEEF, 1'b0, "sw100");
    access(0, 1'b0, LW, 32'h100, 32'h0, 1'b0, "lw100");
    chk("lw100 value", rd[0], 32'hDEAD_BEEF);
    access(0, 1'b1, LB, 32'h102, 32'hFFFF_FF5A, 1'b0, "sb102");
    access(0, 1'b0, LB, 32'h102, 32'h0, 1'b0, "lb102");
    chk("lb102 value", rd[0], 32'h0000_005A);
    access(0, 1'b0, LBU, 32'h103, 32'h0, 1'b0, "lbu103");
    chk("lbu103 value", rd[0], 32'h0000_00DE);
    access(0, 1'b0, LH, 32'h102, 32'h0, 1'b0, "lh102");
    chk("lh102 value", rd[0], 32'hFFFF_DE5A);
    access(0, 1'b0, LHU, 32'h100, 32'h0, 1'b0, "lhu100");
    chk("lhu100 value", rd[0], 32'h0000_BEEF);

    // Misaligned, illegal and out-of-range accesses leave state untouched
    access(0, 1'b0, LW, 32'h101, 32'h0, 1'b0, "lw101 mis");
    chk("lw101 rd held", rd[0], 32'h0000_BEEF);
    access(0, 1'b0, LH, 32'h103, 32'h0, 1'b0, "lh103 mis");
    access(0, 1'b0, 3'b011, 32'h100, 32'h0, 1'b0, "ld f3=011");
    access(0, 1'b1, LW, 32'h1000, 32'h1234_5678, 1'b0, "sw1000 oor");
    access(0, 1'b1, LW, 32'h1100, 32'h0BAD_F00D, 1'b0, "sw1100 alias");
    access(0, 1'b0, LW, 32'h100, 32'h0, 1'b0, "lw100 again");
    chk("lw100 unmodified", rd[0], 32'hDE5A_BEEF);

    // req held through the whole access must be accepted only once
    access(0, 1'b1, LW, 32'h104, 32'h1357_9BDF, 1'b1, "sw104 hold");
    access(0, 1'b0, LW, 32'h104, 32'h0, 1'b0, "lw104");

    // Protected low region
    access(0, 1'b1, LW, 32'h03C, 32'hA5A5_A5A5, 1'b0, "sw03c");
    access(0, 1'b1, LW, 32'h040, 32'h5A5A_5A5A, 1'b0, "sw040");
    access(0, 1'b0, LW, 32'h040, 32'h0, 1'b0, "lw040");
    chk("lw040 value", rd[0], 32'h5A5A_5A5A);
`ifndef PMMU_WRITE_PROTECT_EN
    access(0, 1'b0, LW, 32'h03C, 32'h0, 1'b0, "lw03c");
    chk("lw03c value", rd[0], 32'hA5A5_A5A5);
`endif

    // Reset in the middle of a three-wait-state store aborts it
    access(1, 1'b1, LW, 32'h200, 32'hCAFE_F00D, 1'b0, "ws3 sw200");
    access(1, 1'b0, LW, 32'h200, 32'h0, 1'b0, "ws3 lw200");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; f3[1] = LW; addr[1] = 32'h200; wd[1] = 32'h1122_3344;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("abort busy", 32'(busy[1]), 32'd1);
    @(negedge clk);
    rstn[1] = 1'b0;
    mrd[1]  = 32'd0;
    #1;
    chk("abort rst busy", 32'(busy[1]), 32'd0);
    chk("abort rst rdy",  32'(rdy[1]),  32'd0);
    chk("abort rst rd",   rd[1],        32'd0);
    @(negedge clk);
    rstn[1] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort idle", 32'({busy[1], rdy[1], mis[1], flt[1]}), 32'd0);
    end
    access(1, 1'b0, LW, 32'h200, 32'h0, 1'b0, "ws3 lw200 after");
    chk("abort old word", rd[1], 32'hCAFE_F00D);

    // Zero wait states
    access(2, 1'b1, LW, 32'h080, 32'h8765_4321, 1'b0, "ws0 sw080");
    access(2, 1'b0, LHU, 32'h082, 32'h0, 1'b0, "ws0 lhu082");
    chk("ws0 lhu082 value", rd[2], 32'h0000_8765);

    // Randomized traffic over words 16..79 on the 1- and 0-wait instances
    for (int k = 0; k < NI; k += 2) begin
      for (int wi = 16; wi < 80; wi++) access(k, 1'b1, LW, 32'(wi * 4), $urandom, 1'b0, "init");
      for (int t = 0; t < 80; t++) begin
        rw  = 1'($urandom_range(0, 1));
        rf  = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
        if (!rw && $urandom_range(0, 1) == 1) rf = 3'($urandom);
        ra  = 32'h40 + 32'($urandom_range(0, 255));
        rdv = $urandom;
        if (rw && $urandom_range(0, 7) == 0) ra = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) ra = ra + 32'h1000;
        access(k, rw, rf, ra, rdv, 1'b0, "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pmmu_hs.md
Name: pmmu_hs

Overview:
- Next-generation parametrised processor memory management unit for the multi-cycle RV32I core.
- Replaces the fixed, always-ready memory path with a request/busy/ready handshake and configurable wait states.
- Handles RV32I sub-word loads and stores (byte, half, word), including sign and zero extension.
- Flags misaligned, illegal and out-of-range accesses so the control matrix can stall and trap.

Parameters:
- DATA_WIDTH, 32: data and byte-address width.
- WORDS, 1024: memory depth in DATA_WIDTH words. Word index is byte_addr_i[log2(WORDS)+1:2].
- WAIT_STATES, 1: extra cycles between request acceptance and completion. Range 0..15.
- PROTECT_WORDS, 16: number of low word indices that are write-protected. Used only with the optional feature.

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  1  access request; sampled only in IDLE.
- we_i  in  1  1 = store, 0 = load; sampled with req_i.
- funct3_i  in  3  RV32I size/sign code; sampled with req_i.
- byte_addr_i  in  DATA_WIDTH  byte address; sampled with req_i.
- wd_i  in  DATA_WIDTH  store data, LSB-aligned; sampled with req_i.
- rd_o  out  DATA_WIDTH  load result, extended per funct3.
- busy_o  out  1  high while a request is in flight.
- rdy_o  out  1  one-cycle completion pulse.
- misalign_o  out  1  qualified by rdy_o: half access with addr[0]=1, or word access with addr[1:0]!=0.
- fault_o  out  1  qualified by rdy_o: illegal funct3, out-of-range index, or protected write.

Behaviour:
- Reset (asynchronous assert, synchronous release): FSM=IDLE; rd_o=0, busy_o=0, rdy_o=0, misalign_o=0, fault_o=0. Memory contents are not cleared.
- Resetting mid-operation aborts the access. A store not yet committed is never written.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when req_i=1, latch we/funct3/addr/wd, set busy_o=1 next cycle, load wait counter with WAIT_STATES. Go to WAIT, or directly to DONE if WAIT_STATES=0.
  - WAIT: decrement counter; at 1, go to DONE. busy_o=1.
  - DONE: rdy_o=1 and busy_o=0 for exactly this cycle, then IDLE.
- Latency: request accepted at edge N; rdy_o is high in cycle N+WAIT_STATES+1.
- req_i outside IDLE is ignored; there is no queueing.
- A new req_i may be accepted in the cycle following DONE.
- Error checks run on latched values at acceptance:
  - Misaligned: misalign_o=1.
  - funct3 load not in {000,001,010,100,101}, or store not in {000,001,010}: fault_o=1.
  - Index >= WORDS: fault_o=1.
  - Any error: no memory write, rd_o unchanged. The timing is identical to a good access.
- Store commit: on the edge entering DONE, using byte enables.
  - SB writes lane addr[1:0] with wd[7:0].
  - SH writes lanes {addr[1],0} with wd[15:0].
  - SW writes all four lanes.
- Load: the word is read from the latched index; rd_o updates on the edge entering DONE and holds until the next successful load completes.
  - LB/LBU: lane addr[1:0], sign/zero extended.
  - LH/LHU: lane addr[1], sign/zero extended.
  - LW: full word.
- Stores leave rd_o unchanged.

Optional Feature:
- Macro PMMU_WRITE_PROTECT_EN.
- Defined: a store to word index < PROTECT_WORDS is suppressed and reports fault_o=1 with rdy_o. Loads from that region are unaffected.
- Undefined: PROTECT_WORDS is ignored and all in-range aligned stores commit.

Test Plan:
- WAIT_STATES=1: SW 0xDEADBEEF to 0x100, then LW 0x100 -> rdy_o two cycles after each acceptance; rd_o=0xDEADBEEF; busy_o high exactly one cycle per access.
- After the above: SB 0x5A to 0x102, then LB 0x102 / LBU 0x103 / LH 0x102 / LHU 0x100 -> 0x0000005A / 0x000000DE / 0xFFFFDE5A / 0x0000BEEF.
- LW 0x101 and LH 0x103 -> misalign_o=1 with rdy_o; rd_o keeps its prior value; a following LW 0x100 still returns the unmodified word.
- funct3=011 load, and SW to byte 0x1000 with WORDS=1024 -> fault_o=1 with rdy_o; no memory change. req_i held high while busy -> only one acceptance.
- WAIT_STATES=3: start SW 0x11223344 to 0x200; drive reset_i=0 during WAIT; release -> all outputs 0, FSM idle, later LW 0x200 returns the old value. WAIT_STATES=0: rdy_o in the cycle after acceptance.
- PMMU_WRITE_PROTECT_EN defined: SW to 0x03C -> fault_o=1, word unchanged. SW to 0x040 -> commits, fault_o=0. Undefined: both commit.
